wash_fsm_moore_multi: RTL and testbench

//  Parametrised multi-bay Moore token/spray controller; successor of the single-bay token/spray FSM.
//  N_BAYS independent per-bay FSMs share one clock/reset.

---
 rtl/wash_fsm_moore_multi.sv | 151 +++++++++++++++
 tb/tb_wash_fsm_moore_multi.sv | 169 ++++++++++++++++
 2 files changed

// File: rtl/wash_fsm_moore_multi.sv
// Multi-bay Moore token/spray controller with per-bay spray timer and banked token credits.
// Optional post-spray rinse phase enabled by defining WASH_RINSE_EN.
module wash_fsm_moore_multi #(
  parameter int unsigned N_BAYS       = 4,
  parameter int unsigned SPRAY_CYCLES = 16,
  parameter int unsigned CREDIT_W     = 3,
  parameter int unsigned RINSE_CYCLES = 8
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [N_BAYS-1:0]            token,
  input  logic [N_BAYS-1:0]            abort,
  output logic [N_BAYS-1:0]            clrt,
  output logic [N_BAYS-1:0]            spray,
  output logic [N_BAYS-1:0]            rinse,
  output logic [N_BAYS-1:0]            busy,
  output logic [N_BAYS*CREDIT_W-1:0]   credits
);

  localparam int unsigned TimerMax = (SPRAY_CYCLES > RINSE_CYCLES) ? SPRAY_CYCLES : RINSE_CYCLES;
  localparam int unsigned TimerW   = $clog2(TimerMax);

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StToken = 2'd1,
`ifdef WASH_RINSE_EN
    StSpray = 2'd2,
    StRinse = 2'd3
`else
    StSpray = 2'd2
`endif
  } state_t;

  localparam logic [CREDIT_W-1:0] CredMax = {CREDIT_W{1'b1}};

  state_t              state_q [N_BAYS];
  state_t              state_d [N_BAYS];
  logic [TimerW-1:0]   timer_q [N_BAYS];
  logic [TimerW-1:0]   timer_d [N_BAYS];
  logic [CREDIT_W-1:0] cred_q  [N_BAYS];
  logic [CREDIT_W-1:0] cred_d  [N_BAYS];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < N_BAYS; i++) begin
        state_q[i] <= StIdle;
        timer_q[i] <= '0;
        cred_q[i]  <= '0;
      end
    end else begin
      for (int i = 0; i < N_BAYS; i++) begin
        state_q[i] <= state_d[i];
        timer_q[i] <= timer_d[i];
        cred_q[i]  <= cred_d[i];
      end
    end
  end

  always_comb begin
    for (int i = 0; i < N_BAYS; i++) begin : g_next
      logic consume;
      logic bank;
      logic has_cred;
      state_d[i] = state_q[i];
      timer_d[i] = timer_q[i];
      cred_d[i]  = cred_q[i];
      consume    = 1'b0;
      bank       = token[i] && (state_q[i] != StIdle);
      has_cred   = (cred_q[i] != '0);

      unique case (state_q[i])
        // A token seen in idle starts a cycle directly and is never banked.
        StIdle: begin
          if (token[i]) begin
            state_d[i] = StToken;
          end else if (has_cred) begin
            consume    = 1'b1;
            state_d[i] = StToken;
          end
        end
        StToken: begin
          timer_d[i] = TimerW'(SPRAY_CYCLES - 1);
          state_d[i] = StSpray;
        end
        StSpray: begin
          if (timer_q[i] == '0) begin
            if (has_cred) begin
              consume    = 1'b1;
              state_d[i] = StToken;
            end else begin
`ifdef WASH_RINSE_EN
              timer_d[i] = TimerW'(RINSE_CYCLES - 1);
              state_d[i] = StRinse;
`else
              state_d[i] = StIdle;
`endif
            end
          end else begin
            timer_d[i] = timer_q[i] - TimerW'(1);
          end
        end
`ifdef WASH_RINSE_EN
        StRinse: begin
          if (timer_q[i] == '0) begin
            if (has_cred) begin
              consume    = 1'b1;
              state_d[i] = StToken;
            end else begin
              state_d[i] = StIdle;
            end
          end else begin
            timer_d[i] = timer_q[i] - TimerW'(1);
          end
        end
`endif
        default: state_d[i] = StIdle;
      endcase

      // Bank and consume in the same cycle cancel out.
      if (bank && !consume) begin
        if (cred_q[i] != CredMax) cred_d[i] = cred_q[i] + CREDIT_W'(1);
      end else if (!bank && consume) begin
        cred_d[i] = cred_q[i] - CREDIT_W'(1);
      end

      if (abort[i]) begin
        state_d[i] = StIdle;
        timer_d[i] = '0;
        cred_d[i]  = '0;
      end
    end
  end

  always_comb begin
    clrt    = '0;
    spray   = '0;
    rinse   = '0;
    busy    = '0;
    credits = '0;
    for (int i = 0; i < N_BAYS; i++) begin
      clrt[i]  = (state_q[i] == StToken);
      spray[i] = (state_q[i] == StSpray);
`ifdef WASH_RINSE_EN
      rinse[i] = (state_q[i] == StRinse);
`endif
      busy[i]  = (state_q[i] != StIdle);
      credits[i*CREDIT_W +: CREDIT_W] = cred_q[i];
    end
  end

endmodule

// File: tb/tb_wash_fsm_moore_multi.sv
// Directed bench for wash_fsm_moore_multi (2 bays, 4-cycle spray, 2-bit credits, 3-cycle rinse).
// Define WASH_RINSE_EN to exercise the rinse build instead of the plain build.
module tb_wash_fsm_moore_multi;

  logic       clk;
  logic       reset;
  logic [1:0] token;
  logic [1:0] abort;
  logic [1:0] clrt;
  logic [1:0] spray;
  logic [1:0] rinse;
  logic [1:0] busy;
  logic [3:0] credits;

  typedef struct {
    string       tag;
    logic [11:0] v;
  } exp_t;

  exp_t sb[$];
  int   tests;
  int   fails;

  wash_fsm_moore_multi #(
    .N_BAYS      (2),
    .SPRAY_CYCLES(4),
    .CREDIT_W    (2),
    .RINSE_CYCLES(3)
  ) dut (
    .clk    (clk),
    .reset  (reset),
    .token  (token),
    .abort  (abort),
    .clrt   (clrt),
    .spray  (spray),
    .rinse  (rinse),
    .busy   (busy),
    .credits(credits)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic push(input string tag, input logic [1:0] e_clrt, input logic [1:0] e_spray,
                      input logic [1:0] e_rinse, input logic [1:0] e_busy,
                      input logic [3:0] e_cred);
    exp_t e;
    e.tag = tag;
    e.v   = {e_clrt, e_spray, e_rinse, e_busy, e_cred};
    sb.push_back(e);
  endtask

  task automatic check_out();
    exp_t        e;
    logic [11:0] obs;
    e   = sb.pop_front();
    obs = {clrt, spray, rinse, busy, credits};
    tests++;
    assert (obs === e.v) else begin
      fails++;
      $error("FAIL %s: got clrt/spray/rinse/busy/cred=%b expected %b", e.tag, obs, e.v);
    end
  endtask

  // Drive one cycle of stimulus, expect the given outputs just after the edge.
  task automatic cyc(input logic [1:0] tk, input logic [1:0] ab, input string tag,
                     input logic [1:0] e_clrt, input logic [1:0] e_spray,
                     input logic [1:0] e_rinse, input logic [1:0] e_busy,
                     input logic [3:0] e_cred);
    token = tk;
    abort = ab;
    push(tag, e_clrt, e_spray, e_rinse, e_busy, e_cred);
    @(posedge clk);
    #1;
    token = 2'b00;
    abort = 2'b00;
    check_out();
  endtask

  initial begin
    tests = 0;
    fails = 0;
    reset = 1'b0;
    token = 2'b00;
    abort = 2'b00;
    repeat (2) @(posedge clk);
    #1;
    push("reset_state", 2'b00, 2'b00, 2'b00, 2'b00, 4'd0);
    check_out();
    reset = 1'b1;

`ifndef WASH_RINSE_EN
    // Single token on bay 0, bay 1 untouched.
    cyc(2'b01, 2'b00, "t2_clrt", 2'b01, 2'b00, 2'b00, 2'b01, 4'd0);
    for (int k = 0; k < 4; k++) cyc(2'b00, 2'b00, "t2_spray", 2'b00, 2'b01, 2'b00, 2'b01, 4'd0);
    cyc(2'b00, 2'b00, "t2_idle", 2'b00, 2'b00, 2'b00, 2'b00, 4'd0);

    // Two banked tokens give three back-to-back bursts.
    cyc(2'b01, 2'b00, "t3_clrt", 2'b01, 2'b00, 2'b00, 2'b01, 4'd0);
    cyc(2'b00, 2'b00, "t3_sp0", 2'b00, 2'b01, 2'b00, 2'b01, 4'd0);
    cyc(2'b01, 2'b00, "t3_bank1", 2'b00, 2'b01, 2'b00, 2'b01, 4'd1);
    cyc(2'b01, 2'b00, "t3_bank2", 2'b00, 2'b01, 2'b00, 2'b01, 4'd2);
    cyc(2'b00, 2'b00, "t3_sp3", 2'b00, 2'b01, 2'b00, 2'b01, 4'd2);
    cyc(2'b00, 2'b00, "t3_gap1", 2'b01, 2'b00, 2'b00, 2'b01, 4'd1);
    for (int k = 0; k < 4; k++) cyc(2'b00, 2'b00, "t3_burst2", 2'b00, 2'b01, 2'b00, 2'b01, 4'd1);
    cyc(2'b00, 2'b00, "t3_gap2", 2'b01, 2'b00, 2'b00, 2'b01, 4'd0);
    for (int k = 0; k < 4; k++) cyc(2'b00, 2'b00, "t3_burst3", 2'b00, 2'b01, 2'b00, 2'b01, 4'd0);
    cyc(2'b00, 2'b00, "t3_idle", 2'b00, 2'b00, 2'b00, 2'b00, 4'd0);

    // Bay 1 saturation and net-zero token on consume.
    cyc(2'b10, 2'b00, "t4_clrt", 2'b10, 2'b00, 2'b00, 2'b10, 4'd0);
    cyc(2'b10, 2'b00, "t4_c1", 2'b00, 2'b10, 2'b00, 2'b10, 4'b0100);
    cyc(2'b10, 2'b00, "t4_c2", 2'b00, 2'b10, 2'b00, 2'b10, 4'b1000);
    cyc(2'b10, 2'b00, "t4_c3", 2'b00, 2'b10, 2'b00, 2'b10, 4'b1100);
    cyc(2'b10, 2'b00, "t4_sat", 2'b00, 2'b10, 2'b00, 2'b10, 4'b1100);
    cyc(2'b10, 2'b00, "t4_net0", 2'b10, 2'b00, 2'b00, 2'b10, 4'b1100);
    cyc(2'b00, 2'b10, "t4_abort", 2'b00, 2'b00, 2'b00, 2'b00, 4'd0);

    // Token on the expiry cycle with no credit: bank, idle, then restart.
    cyc(2'b01, 2'b00, "tx_clrt", 2'b01, 2'b00, 2'b00, 2'b01, 4'd0);
    for (int k = 0; k < 4; k++) cyc(2'b00, 2'b00, "tx_spray", 2'b00, 2'b01, 2'b00, 2'b01, 4'd0);
    cyc(2'b01, 2'b00, "tx_bank_idle", 2'b00, 2'b00, 2'b00, 2'b00, 4'd1);
    cyc(2'b00, 2'b00, "tx_restart", 2'b01, 2'b00, 2'b00, 2'b01, 4'd0);
    for (int k = 0; k < 4; k++) cyc(2'b00, 2'b00, "tx_spray2", 2'b00, 2'b01, 2'b00, 2'b01, 4'd0);
    cyc(2'b00, 2'b00, "tx_idle", 2'b00, 2'b00, 2'b00, 2'b00, 4'd0);

    // Abort with credits, then abort dominating token.
    cyc(2'b01, 2'b00, "t5_clrt", 2'b01, 2'b00, 2'b00, 2'b01, 4'd0);
    cyc(2'b01, 2'b00, "t5_c1", 2'b00, 2'b01, 2'b00, 2'b01, 4'd1);
    cyc(2'b01, 2'b00, "t5_c2", 2'b00, 2'b01, 2'b00, 2'b01, 4'd2);
    cyc(2'b00, 2'b01, "t5_abort", 2'b00, 2'b00, 2'b00, 2'b00, 4'd0);
    cyc(2'b01, 2'b01, "t5_abort_tok", 2'b00, 2'b00, 2'b00, 2'b00, 4'd0);
    cyc(2'b00, 2'b00, "t5_stay", 2'b00, 2'b00, 2'b00, 2'b00, 4'd0);
`else
    // Rinse after final spray, token during rinse restarts afterwards.
    cyc(2'b01, 2'b00, "t6_clrt", 2'b01, 2'b00, 2'b00, 2'b01, 4'd0);
    for (int k = 0; k < 4; k++) cyc(2'b00, 2'b00, "t6_spray", 2'b00, 2'b01, 2'b00, 2'b01, 4'd0);
    for (int k = 0; k < 3; k++) cyc(2'b00, 2'b00, "t6_rinse", 2'b00, 2'b00, 2'b01, 2'b01, 4'd0);
    cyc(2'b00, 2'b00, "t6_idle", 2'b00, 2'b00, 2'b00, 2'b00, 4'd0);
    cyc(2'b01, 2'b00, "t6_clrt2", 2'b01, 2'b00, 2'b00, 2'b01, 4'd0);
    for (int k = 0; k < 4; k++) cyc(2'b00, 2'b00, "t6_spray2", 2'b00, 2'b01, 2'b00, 2'b01, 4'd0);
    cyc(2'b00, 2'b00, "t6_r0", 2'b00, 2'b00, 2'b01, 2'b01, 4'd0);
    cyc(2'b01, 2'b00, "t6_r1_bank", 2'b00, 2'b00, 2'b01, 2'b01, 4'd1);
    cyc(2'b00, 2'b00, "t6_r2", 2'b00, 2'b00, 2'b01, 2'b01, 4'd1);
    cyc(2'b00, 2'b00, "t6_restart", 2'b01, 2'b00, 2'b00, 2'b01, 4'd0);
    for (int k = 0; k < 4; k++) cyc(2'b00, 2'b00, "t6_spray3", 2'b00, 2'b01, 2'b00, 2'b01, 4'd0);
    for (int k = 0; k < 3; k++) cyc(2'b00, 2'b00, "t6_rinse3", 2'b00, 2'b00, 2'b01, 2'b01, 4'd0);
    cyc(2'b00, 2'b00, "t6_idle3", 2'b00, 2'b00, 2'b00, 2'b00, 4'd0);
`endif

    // Asynchronous reset in the middle of a spray with a banked credit.
    cyc(2'b01, 2'b00, "t1_clrt", 2'b01, 2'b00, 2'b00, 2'b01, 4'd0);
    cyc(2'b00, 2'b00, "t1_sp0", 2'b00, 2'b01, 2'b00, 2'b01, 4'd0);
    cyc(2'b01, 2'b00, "t1_bank", 2'b00, 2'b01, 2'b00, 2'b01, 4'd1);
    #2;
    reset = 1'b0;
    #1;
    push("t1_async", 2'b00, 2'b00, 2'b00, 2'b00, 4'd0);
    check_out();
    #2;
    reset = 1'b1;
    cyc(2'b00, 2'b00, "t1_stay0", 2'b00, 2'b00, 2'b00, 2'b00, 4'd0);
    cyc(2'b00, 2'b00, "t1_stay1", 2'b00, 2'b00, 2'b00, 2'b00, 4'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
